instr_prefetch: RTL and testbench
=================================

INSTR_PREFETCH -- requirements
Module: instr_prefetch

Interface
REQ-001 Parameter DEPTH, default 2, sets instruction FIFO entries and the maximum number of outstanding memory requests.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 boot_addr  in  32  first fetch address after reset.
REQ-005 redirect_valid  in  1  branch/jump redirect from execute; one-cycle pulse.
REQ-006 redirect_addr  in  32  new fetch PC; bits [1:0] ignored.
REQ-007 imem_req  out  1  fetch request to instruction memory.
REQ-008 imem_addr  out  32  word-aligned fetch address.
REQ-009 imem_gnt  in  1  request accepted when imem_req && imem_gnt.
REQ-010 imem_rvalid  in  1  in-order response valid, at least 1 cycle after grant.
REQ-011 imem_rdata  in  32  response instruction word.
REQ-012 if_valid  out  1  head FIFO entry is valid for decode.
REQ-013 if_ready  in  1  decode accepts the head entry; pop when if_valid && if_ready.
REQ-014 if_instr, if_pc, if_pc_plus_4  out  32 each  head instruction, its PC, and PC+4 (mod 2^32).

Function
REQ-015 The FSM SHALL have states IDLE, FETCH and FLUSH.
REQ-016 IDLE is entered on reset; the next cycle goes to FETCH with fetch_addr = {boot_addr[31:2],2'b00}.
REQ-017 FETCH issues requests: imem_req = (outstanding + fifo_count < DEPTH).
REQ-018 imem_addr SHALL hold stable while imem_req && !imem_gnt, unless a redirect occurs.
REQ-019 Each grant SHALL advance fetch_addr by 4, wrapping from 0xFFFFFFFC to 0x00000000.
REQ-020 Each grant SHALL push the granted address into an in-order PC tag queue, which is popped on each non-discarded rvalid.
REQ-021 A non-discarded rvalid SHALL write {rdata, tag PC} into the FIFO; the entry is visible on if_* the next cycle (no bypass).
REQ-022 The credit rule in REQ-017 guarantees no FIFO overflow; an rvalid while fifo_count == DEPTH is a protocol error and is asserted in simulation.
REQ-023 On redirect_valid: FIFO and PC tag queue are cleared, fetch_addr = {redirect_addr[31:2],2'b00}, discard = outstanding count (including any grant in the same cycle), and if_valid drops the next cycle.
REQ-024 A redirect moves the FSM to FLUSH if discard > 0, otherwise to FETCH.
REQ-025 In FLUSH, imem_req = 0; each rvalid decrements discard and its data is dropped; the FSM goes to FETCH when the last discard arrives.
REQ-026 Redirect latency with immediate grant and 1-cycle response: redirect at N, req at N+1, rvalid at N+2, if_valid at N+3.
REQ-027 Redirect in the same cycle as a pop or rvalid: the redirect wins, the pop is a no-op and a same-cycle old-stream rvalid counts as discarded.
REQ-028 Redirect while in FLUSH SHALL recompute discard from the current outstanding count and load the new address.
REQ-029 Pop and push in the same cycle SHALL keep fifo_count unchanged.
REQ-030 An rvalid with outstanding == 0 SHALL be ignored.

Reset
REQ-031 While rst_n = 0: imem_req = 0, imem_addr = 0, if_valid = 0, if_instr = NOP (0x00000013), if_pc = 0, if_pc_plus_4 = 0, and all counters, FIFO and tag queue are empty.
REQ-032 Reset asserted mid-operation SHALL abandon outstanding requests; late responses are dropped per REQ-030.

Structure
REQ-033 The types package SHALL hold prefetch_state_t and the NOP constant.
REQ-034 The FIFO SHALL be a separate sub-module, fetch_fifo (parameter DEPTH, WIDTH = 64, push/pop/flush/full/empty/count).
REQ-035 The PC tag queue SHALL reuse fetch_fifo with WIDTH = 32.

Verification
REQ-036 Reset with boot_addr = 0x100, gnt = 1, 1-cycle response: if_pc sequence 0x100, 0x104, 0x108; if_valid first high 3 cycles after reset release.
REQ-037 Hold if_ready = 0 with DEPTH = 2: exactly 2 grants then imem_req = 0; on release, 0x100 and 0x104 are delivered in order with no loss.
REQ-038 Hold gnt = 0 for 3 cycles: imem_addr stays 0x100 and no tag is pushed.
REQ-039 With 2 requests outstanding, redirect to 0x203: FSM in FLUSH, 2 responses dropped, next if_pc = 0x200.
REQ-040 Redirect to 0xFFFFFFF8: delivered PCs are 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; if_pc_plus_4 for 0xFFFFFFFC is 0.
REQ-041 Redirect coincident with pop and rvalid: nothing from the old stream reaches decode, and the first instruction delivered is the one from redirect_addr.

Source files
------------

// File: rtl/instr_prefetch_pkg.sv
// instr_prefetch_pkg: shared types and constants for the instruction prefetcher
package instr_prefetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} prefetch_state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush, used for instructions and PC tags
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= inc(wr_ptr);
      if (do_pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (rst_n && !flush && do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/instr_prefetch.sv
// instr_prefetch: credit-limited instruction prefetcher with redirect flush
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] boot_addr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4
);
  localparam int CW = $clog2(DEPTH + 1);
  prefetch_state_t state, state_next;
  logic [31:0] fetch_addr, tag_pc;
  logic [63:0] head;
  logic [CW-1:0] outstanding, outstanding_next, discard, fifo_count, tag_count;
  logic grant, rv, rv_live, fifo_full, fifo_empty, tag_full, tag_empty;
  assign grant = imem_req && imem_gnt;
  assign rv = imem_rvalid && outstanding != '0;
  // A response is only kept when no older-stream discards remain and no redirect lands this cycle
  assign rv_live = rv && discard == '0 && !redirect_valid;
  assign outstanding_next = outstanding + CW'(grant) - CW'(rv);
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_next;
  end
  always_comb begin
    state_next = redirect_valid ? (outstanding_next != '0 ? FLUSH : FETCH) :
                 state == IDLE ? FETCH :
                 (state == FLUSH && rv && discard == CW'(1)) ? FETCH : state;
  end
  always_comb begin
    imem_req = state == FETCH && ({1'b0, outstanding} + {1'b0, fifo_count} < (CW+1)'(DEPTH));
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_addr <= '0;
      outstanding <= '0;
      discard <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_addr <= redirect_addr & 32'hFFFF_FFFC;
        discard <= outstanding_next;
      end else begin
        if (state == IDLE) fetch_addr <= boot_addr & 32'hFFFF_FFFC;
        else if (grant) fetch_addr <= fetch_addr + 32'd4;
        if (rv && discard != '0) discard <= discard - CW'(1);
      end
    end
  end
  assign imem_addr = fetch_addr;
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk(clk), .rst_n(rst_n),
    .push(rv_live), .pop(if_valid && if_ready), .flush(redirect_valid),
    .din({imem_rdata, tag_pc}), .dout(head),
    .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_tags (
    .clk(clk), .rst_n(rst_n),
    .push(grant), .pop(rv_live), .flush(redirect_valid),
    .din(fetch_addr), .dout(tag_pc),
    .full(tag_full), .empty(tag_empty), .count(tag_count)
  );
  assign if_valid = !fifo_empty;
  assign if_instr = if_valid ? head[63:32] : NOP;
  assign if_pc = if_valid ? head[31:0] : '0;
  assign if_pc_plus_4 = if_valid ? head[31:0] + 32'd4 : '0;
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(rv_live && fifo_full));
  a_tag_present: assert property (@(posedge clk) disable iff (!rst_n) !(rv_live && tag_empty));
  a_tag_room:    assert property (@(posedge clk) disable iff (!rst_n) !(grant && tag_full && !redirect_valid));
  a_tag_track:   assert property (@(posedge clk) disable iff (!rst_n) state != FETCH || tag_count == outstanding);
endmodule

// File: tb/tb_instr_prefetch.sv
// tb_instr_prefetch: self-checking bench with an in-order memory responder and a stream model
module tb_instr_prefetch;
  localparam int DEPTH = 2;
  localparam logic [31:0] BOOT = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk, rst_n, redirect_valid, imem_req, imem_gnt, imem_rvalid, if_valid, if_ready;
  logic [31:0] boot_addr, redirect_addr, imem_addr, imem_rdata, if_instr, if_pc, if_pc_plus_4;
  int n_cmp, n_fail, rsp_pct, grants, pops, g0, p0;
  logic [31:0] mq[$];
  logic [31:0] popped[$];
  logic [31:0] popped4[$];
  logic [31:0] fetch_exp, pop_exp;
  typedef struct { logic [31:0] addr; logic [31:0] pc; logic [31:0] pc4; } vec_t;
  vec_t vecs[5];

  instr_prefetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .boot_addr(boot_addr),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  function automatic logic [31:0] pc_at(input int i);
    return popped.size() > i ? popped[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory answers every grant in order, with random delay of at least one cycle
  task automatic tick();
    if (mq.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
      imem_rvalid = 1;
      imem_rdata = mem_fn(mq.pop_front());
    end else begin
      imem_rvalid = 0;
      imem_rdata = $urandom;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_hold(input logic rdy, input logic gnt, input int pct);
    rst_n = 0;
    redirect_valid = 0;
    if_ready = rdy;
    imem_gnt = gnt;
    rsp_pct = pct;
    tick();
    tick();
    popped.delete();
    popped4.delete();
    rst_n = 1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_if_instr", if_instr, NOP);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_pc_plus_4", if_pc_plus_4, 0);
  endtask

  task automatic wait_pops(input int n, input string name);
    int b = 0;
    while (popped.size() < n && b < 200) begin
      tick();
      b++;
    end
    chk({name, "_delivered"}, 32'(popped.size() >= n), 1);
  endtask

  task automatic redirect(input logic [31:0] a);
    redirect_valid = 1;
    redirect_addr = a;
    tick();
    redirect_valid = 0;
  endtask

  // Stream model: grants and deliveries must each follow the current program-order stream
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      fetch_exp = BOOT & 32'hFFFF_FFFC;
      pop_exp = fetch_exp;
    end else begin
      if (imem_req && imem_gnt) begin
        chk("grant_addr", imem_addr, fetch_exp);
        fetch_exp += 32'd4;
        mq.push_back(imem_addr);
        grants++;
        chk("credit", 32'(mq.size() <= DEPTH), 1);
      end
      if (if_valid && if_ready && !redirect_valid) begin
        chk("pop_pc", if_pc, pop_exp);
        chk("pop_instr", if_instr, mem_fn(pop_exp));
        chk("pop_pc_plus_4", if_pc_plus_4, pop_exp + 32'd4);
        popped.push_back(if_pc);
        popped4.push_back(if_pc_plus_4);
        pop_exp += 32'd4;
        pops++;
      end
      if (redirect_valid) begin
        fetch_exp = redirect_addr & 32'hFFFF_FFFC;
        pop_exp = fetch_exp;
      end
    end
  end

  initial begin
    vecs[0] = '{32'h0000_0203, 32'h0000_0200, 32'h0000_0204};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[2] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0004};
    vecs[3] = '{32'h0000_1001, 32'h0000_1000, 32'h0000_1004};
    vecs[4] = '{32'h7FFF_FFFE, 32'h7FFF_FFFC, 32'h8000_0000};
    n_cmp = 0; n_fail = 0; grants = 0; pops = 0;
    boot_addr = BOOT;
    redirect_addr = 0;
    redirect_valid = 0;
    imem_gnt = 1;
    if_ready = 1;
    imem_rvalid = 0;
    imem_rdata = 0;
    rsp_pct = 100;
    rst_n = 0;
    tick();
    tick();
    chk_reset_vals();
    // Boot stream timing: release in cycle N, first instruction visible at N+3
    popped.delete();
    popped4.delete();
    rst_n = 1;
    tick();
    chk("boot_n1_req", 32'(imem_req), 1);
    chk("boot_n1_addr", imem_addr, BOOT);
    chk("boot_n1_valid", 32'(if_valid), 0);
    tick();
    chk("boot_n2_valid", 32'(if_valid), 0);
    tick();
    chk("boot_n3_valid", 32'(if_valid), 1);
    chk("boot_n3_pc", if_pc, BOOT);
    wait_pops(3, "boot_seq");
    chk("boot_seq0", pc_at(0), 32'h100);
    chk("boot_seq1", pc_at(1), 32'h104);
    chk("boot_seq2", pc_at(2), 32'h108);
    // Decode stalled: credits allow exactly DEPTH grants
    reset_hold(0, 1, 100);
    g0 = grants;
    for (int i = 0; i < 10; i++) tick();
    chk("stall_grants", 32'(grants - g0), DEPTH);
    chk("stall_req", 32'(imem_req), 0);
    chk("stall_head", if_pc, 32'h100);
    // Redirect with nothing outstanding: req at N+1, if_valid at N+3
    redirect(32'h0000_0500);
    chk("lat_n1_valid", 32'(if_valid), 0);
    chk("lat_n1_req", 32'(imem_req), 1);
    chk("lat_n1_addr", imem_addr, 32'h500);
    tick();
    chk("lat_n2_valid", 32'(if_valid), 0);
    tick();
    chk("lat_n3_valid", 32'(if_valid), 1);
    chk("lat_n3_pc", if_pc, 32'h500);
    reset_hold(0, 1, 100);
    for (int i = 0; i < 10; i++) tick();
    if_ready = 1;
    wait_pops(2, "release");
    chk("release0", pc_at(0), 32'h100);
    chk("release1", pc_at(1), 32'h104);
    // No grant: address holds and nothing is tagged
    reset_hold(1, 0, 100);
    tick();
    g0 = grants;
    for (int i = 0; i < 3; i++) begin
      chk("nognt_req", 32'(imem_req), 1);
      chk("nognt_addr", imem_addr, BOOT);
      tick();
    end
    chk("nognt_grants", 32'(grants - g0), 0);
    chk("nognt_valid", 32'(if_valid), 0);
    imem_gnt = 1;
    wait_pops(1, "nognt_first");
    chk("nognt_first_pc", pc_at(0), BOOT);
    // Two outstanding, redirect drops both responses
    reset_hold(1, 1, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("flush_outstanding", 32'(mq.size()), 2);
    redirect(32'h0000_0203);
    chk("flush_req", 32'(imem_req), 0);
    chk("flush_addr", imem_addr, 32'h200);
    chk("flush_valid", 32'(if_valid), 0);
    rsp_pct = 100;
    popped.delete();
    wait_pops(1, "flush_first");
    chk("flush_first_pc", pc_at(0), 32'h200);
    // Redirect again while still flushing
    rsp_pct = 0;
    for (int i = 0; i < 8; i++) tick();
    redirect(32'h0000_0603);
    redirect(32'h0000_0703);
    chk("reflush_req", 32'(imem_req), 0);
    chk("reflush_addr", imem_addr, 32'h700);
    rsp_pct = 100;
    popped.delete();
    wait_pops(1, "reflush_first");
    chk("reflush_first_pc", pc_at(0), 32'h700);
    // Address wrap at the top of memory
    popped.delete();
    popped4.delete();
    redirect(32'hFFFF_FFF8);
    wait_pops(3, "wrap");
    chk("wrap0", pc_at(0), 32'hFFFF_FFF8);
    chk("wrap1", pc_at(1), 32'hFFFF_FFFC);
    chk("wrap2", pc_at(2), 32'h0000_0000);
    chk("wrap1_pc4", popped4.size() > 1 ? popped4[1] : 32'hDEAD_DEAD, 32'h0);
    // Redirect coinciding with a pop and an old-stream response
    for (int i = 0; i < 50 && !(if_valid && mq.size() > 0); i++) tick();
    chk("coincide_setup", 32'(if_valid && mq.size() > 0), 1);
    popped.delete();
    redirect(32'h0000_0800);
    chk("coincide_rvalid", 32'(imem_rvalid), 1);
    chk("coincide_valid_drop", 32'(if_valid), 0);
    wait_pops(1, "coincide_first");
    chk("coincide_first_pc", pc_at(0), 32'h800);
    // Table of redirect targets and the PC values decode must see
    for (int i = 0; i < 5; i++) begin
      popped.delete();
      popped4.delete();
      redirect(vecs[i].addr);
      wait_pops(1, "vec");
      chk("vec_pc", pc_at(0), vecs[i].pc);
      chk("vec_pc4", popped4.size() > 0 ? popped4[0] : 32'hDEAD_DEAD, vecs[i].pc4);
    end
    // Reset mid-operation abandons requests; stray late responses are ignored
    rsp_pct = 0;
    for (int i = 0; i < 4; i++) tick();
    rst_n = 0;
    tick();
    chk_reset_vals();
    tick();
    popped.delete();
    rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      imem_rvalid = 1;
      imem_rdata = 32'h0BAD_0BAD;
      @(posedge clk);
      #1;
    end
    rsp_pct = 100;
    wait_pops(1, "midrst_first");
    chk("midrst_first_pc", pc_at(0), BOOT);
    // Randomized traffic against the stream model
    reset_hold(1, 1, 60);
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      imem_gnt = $urandom_range(0, 3) != 0;
      if_ready = $urandom_range(0, 3) != 0;
      redirect_valid = i > 4 && $urandom_range(0, 24) == 0;
      redirect_addr = $urandom;
      tick();
    end
    redirect_valid = 0;
    chk("random_progress", 32'(pops - p0 > 300), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
